// File: rtl/nlms_seq_ctrl.sv
// nlms_seq_ctrl
//   Per-sample sequencer for the NLMS echo canceller. It accepts one (x, d)
//   sample pair and writes x into the circular u buffer, replacing the oldest
//   entry. It keeps the running input energy (sumu) and starts the FIR. It
//   forms e = d - y with saturation, then optionally runs the weight update.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   i_sample_valid/o_sample_ready sample handshake (accepted only in IDLE)
//   i_x_in, i_d_in, i_adapt_en    reference, desired, adapt enable
//   o_u_wr_*                      u-buffer write port
//   o_u_rd_addr, i_u_rd_data      u-buffer read port (1-cycle latency)
//   o_head                        index of newest sample
//   o_sumu                        max(energy, SUMU_MIN)
//   o_fir_start, i_fir_done,
//   i_fir_y                       FIR handshake and result
//   o_e_n_data                    error held for the weight-update engine
//   o_w_update_start, i_w_finsh   weight-update handshake
//   o_y_out, o_e_out, o_out_valid per-sample outputs
//   o_busy, o_timeout_err         status (timeout is sticky until reset)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a sample
// RD_OLD   | read address of the oldest sample presented to the RAM
// WAIT_OLD | RAM data returns; oldest sample captured at end of cycle
// WRITE    | write new sample, advance head, update energy
// FIR      | fir_start pulse, wait for fir_done (timed)
// ERR      | e = sat(d - y), register outputs
// WUPD     | hold w_update_start until w_finsh (timed)
// DONE     | out_valid pulse

module nlms_seq_ctrl #(
  parameter int TAPS       = 512,
  parameter int ADDR_W     = 9,
  parameter int DATA_WIDTH = 16,
  parameter int SUMU_W     = 41,
  parameter int SUMU_MIN   = 1,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_sample_valid,
  output logic                  o_sample_ready,
  input  logic [DATA_WIDTH-1:0] i_x_in,
  input  logic [DATA_WIDTH-1:0] i_d_in,
  input  logic                  i_adapt_en,
  output logic                  o_u_wr_en,
  output logic [ADDR_W-1:0]     o_u_wr_addr,
  output logic [DATA_WIDTH-1:0] o_u_wr_data,
  output logic [ADDR_W-1:0]     o_u_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_u_rd_data,
  output logic [ADDR_W-1:0]     o_head,
  output logic [SUMU_W-1:0]     o_sumu,
  output logic                  o_fir_start,
  input  logic                  i_fir_done,
  input  logic [DATA_WIDTH-1:0] i_fir_y,
  output logic [DATA_WIDTH-1:0] o_e_n_data,
  output logic                  o_w_update_start,
  input  logic                  i_w_finsh,
  output logic [DATA_WIDTH-1:0] o_y_out,
  output logic [DATA_WIDTH-1:0] o_e_out,
  output logic                  o_out_valid,
  output logic                  o_busy,
  output logic                  o_timeout_err
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(TAPS - 1);

  typedef enum logic [2:0] {
    IDLE, RD_OLD, WAIT_OLD, WRITE, FIR, ERR, WUPD, DONE
  } state_t;

  state_t r_state, w_state_nxt;
  logic   w_accept, w_tmo;

  logic [DATA_WIDTH-1:0]        r_x, r_d, r_x_old, r_y, r_y_out, r_e;
  logic                         r_adapt;
  logic [ADDR_W-1:0]            r_ptr, r_head;
  logic signed [SUMU_W-1:0]     r_energy;
  logic [SUMU_W-1:0]            r_sumu;
  logic [TMR_W-1:0]             r_tmr;
  logic                         r_fir_start, r_wus, r_terr;

  logic signed [2*DATA_WIDTH-1:0] w_xsq, w_osq;
  logic signed [SUMU_W-1:0]       w_sum, w_energy_nxt;
  logic signed [DATA_WIDTH:0]     w_e_wide;
  logic [DATA_WIDTH-1:0]          w_e_sat;
  logic [ADDR_W-1:0]              w_ptr_nxt;

  // Energy is a sliding sum of squares; the clamp only guards against a
  // buffer that was not cleared at reset.
  assign w_xsq = $signed(r_x) * $signed(r_x);
  assign w_osq = $signed(r_x_old) * $signed(r_x_old);
  assign w_sum = r_energy + SUMU_W'(w_xsq) - SUMU_W'(w_osq);
  assign w_energy_nxt = w_sum[SUMU_W-1] ? '0 : w_sum;

  assign w_e_wide = {r_d[DATA_WIDTH-1], r_d} - {r_y[DATA_WIDTH-1], r_y};
  always_comb begin
    w_e_sat = w_e_wide[DATA_WIDTH-1:0];
    if (w_e_wide[DATA_WIDTH] != w_e_wide[DATA_WIDTH-1])
      w_e_sat = w_e_wide[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                     : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end

  assign w_ptr_nxt = (r_head == ADDR_LAST) ? '0 : r_head + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    w_tmo          = 1'b0;
    o_sample_ready = 1'b0;
    o_u_wr_en      = 1'b0;
    o_out_valid    = 1'b0;
    o_busy         = 1'b1;
    case (r_state)
      IDLE: begin
        o_sample_ready = 1'b1;
        o_busy         = 1'b0;
        if (i_sample_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RD_OLD;
        end
      end
      RD_OLD:   w_state_nxt = WAIT_OLD;
      WAIT_OLD: w_state_nxt = WRITE;
      WRITE: begin
        o_u_wr_en   = 1'b1;
        w_state_nxt = FIR;
      end
      FIR: begin
        if (i_fir_done) w_state_nxt = ERR;
        else if (r_tmr == '0) begin
          w_tmo       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      ERR: w_state_nxt = r_adapt ? WUPD : DONE;
      WUPD: begin
        // completion takes priority over a simultaneous timer expiry
        if (i_w_finsh) w_state_nxt = DONE;
        else if (r_tmr == '0) begin
          w_tmo       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      DONE: begin
        o_out_valid = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x         <= '0;
      r_d         <= '0;
      r_adapt     <= 1'b0;
      r_x_old     <= '0;
      r_y         <= '0;
      r_y_out     <= '0;
      r_e         <= '0;
      r_ptr       <= '0;
      r_head      <= ADDR_LAST;
      r_energy    <= '0;
      r_sumu      <= SUMU_W'(SUMU_MIN);
      r_tmr       <= '0;
      r_fir_start <= 1'b0;
      r_wus       <= 1'b0;
      r_terr      <= 1'b0;
    end else begin
      r_fir_start <= 1'b0;
      if (w_tmo) r_terr <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x     <= i_x_in;
            r_d     <= i_d_in;
            r_adapt <= i_adapt_en;
            r_ptr   <= w_ptr_nxt;
          end
        end
        WAIT_OLD: r_x_old <= i_u_rd_data;
        WRITE: begin
          r_head      <= r_ptr;
          r_energy    <= w_energy_nxt;
          r_sumu      <= (w_energy_nxt < SUMU_MIN) ? SUMU_W'(SUMU_MIN)
                                                   : w_energy_nxt;
          r_tmr       <= TMR_LOAD;
          r_fir_start <= 1'b1;
        end
        FIR: begin
          if (i_fir_done)      r_y   <= i_fir_y;
          else if (r_tmr != '0) r_tmr <= r_tmr - TMR_W'(1);
        end
        ERR: begin
          r_e     <= w_e_sat;
          r_y_out <= r_y;
          if (r_adapt) begin
            r_wus <= 1'b1;
            r_tmr <= TMR_LOAD;
          end
        end
        WUPD: begin
          if (i_w_finsh || r_tmr == '0) r_wus <= 1'b0;
          else                          r_tmr <= r_tmr - TMR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_u_wr_addr      = r_ptr;
  assign o_u_wr_data      = r_x;
  assign o_u_rd_addr      = r_ptr;
  assign o_head           = r_head;
  assign o_sumu           = r_sumu;
  assign o_fir_start      = r_fir_start;
  assign o_e_n_data       = r_e;
  assign o_e_out          = r_e;
  assign o_y_out          = r_y_out;
  assign o_w_update_start = r_wus;
  assign o_timeout_err    = r_terr;

endmodule

// File: tb/tb_nlms_seq_ctrl.sv
// tb_nlms_seq_ctrl
//   Bench for nlms_seq_ctrl. Provides a 512-entry u-buffer RAM with a
//   1-cycle read latency that is cleared at reset. It also provides FIR and
//   weight-update responders. The reference model is the window of the last
//   512 written samples; expected energy is the plain sum of squares.
module tb_nlms_seq_ctrl;
  localparam int TAPS = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_sample_valid = 1'b0;
  logic        o_sample_ready;
  logic [15:0] i_x_in = '0, i_d_in = '0;
  logic        i_adapt_en = 1'b0;
  logic        o_u_wr_en;
  logic [8:0]  o_u_wr_addr, o_u_rd_addr, o_head;
  logic [15:0] o_u_wr_data, i_u_rd_data;
  logic [40:0] o_sumu;
  logic        o_fir_start, i_fir_done = 1'b0;
  logic [15:0] i_fir_y = '0, o_e_n_data, o_y_out, o_e_out;
  logic        o_w_update_start, i_w_finsh = 1'b0;
  logic        o_out_valid, o_busy, o_timeout_err;

  int n_checks = 0, n_errors = 0;

  longint win[TAPS];
  int     cnt;
  bit     exp_terr;

  nlms_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_sample_valid(i_sample_valid), .o_sample_ready(o_sample_ready),
    .i_x_in(i_x_in), .i_d_in(i_d_in), .i_adapt_en(i_adapt_en),
    .o_u_wr_en(o_u_wr_en), .o_u_wr_addr(o_u_wr_addr), .o_u_wr_data(o_u_wr_data),
    .o_u_rd_addr(o_u_rd_addr), .i_u_rd_data(i_u_rd_data), .o_head(o_head),
    .o_sumu(o_sumu), .o_fir_start(o_fir_start), .i_fir_done(i_fir_done),
    .i_fir_y(i_fir_y), .o_e_n_data(o_e_n_data),
    .o_w_update_start(o_w_update_start), .i_w_finsh(i_w_finsh),
    .o_y_out(o_y_out), .o_e_out(o_e_out), .o_out_valid(o_out_valid),
    .o_busy(o_busy), .o_timeout_err(o_timeout_err)
  );

  always #5 clk = ~clk;

  logic [15:0] ram [TAPS];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) ram[i] <= '0;
      i_u_rd_data <= '0;
    end else begin
      if (o_u_wr_en) ram[o_u_wr_addr] <= o_u_wr_data;
      i_u_rd_data <= ram[o_u_rd_addr];
    end
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rnd16();
    logic signed [15:0] v;
    v = 16'($urandom);
    return int'(v);
  endfunction

  function automatic longint model_sumu();
    longint s = 0;
    for (int i = 0; i < TAPS; i++) s += win[i] * win[i];
    return (s < 1) ? 1 : s;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < TAPS; i++) win[i] = 0;
    cnt = 0;
    exp_terr = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    i_sample_valid = 0; i_fir_done = 0; i_w_finsh = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  // One sample end to end. fir_lat/w_lat are responder delays in cycles,
  // withhold suppresses fir_done, rst_wupd pulls reset during WUPD.
  task automatic run_sample(input int x, input int d, input int y, input bit adapt,
                            input int fir_lat, input int w_lat,
                            input bit withhold, input bit rst_wupd);
    int cyc, g, fs_cyc, dn_cyc, ov_cyc, wus_cyc, exit_cyc, exp_ptr, n_ov;
    bit bad_rdy, wus_drop, got_wr, hold;
    longint exp_sumu, de, exp_e;
    exp_ptr = cnt % TAPS;
    de = longint'(d) - longint'(y);
    exp_e = (de > 32767) ? 32767 : (de < -32768) ? -32768 : de;
    hold = 1'($urandom);
    g = 0;
    while (!o_sample_ready && g < 100) begin @(negedge clk); g++; end
    check_eq("ready_wait", o_sample_ready, 1);
    i_sample_valid = 1; i_x_in = 16'(x); i_d_in = 16'(d); i_adapt_en = adapt;
    @(negedge clk);
    i_sample_valid = 0;
    win[exp_ptr] = x; cnt++;
    exp_sumu = model_sumu();
    cyc = 1; fs_cyc = -1; dn_cyc = -1; ov_cyc = -1; wus_cyc = -1; exit_cyc = -1;
    n_ov = 0; bad_rdy = 0; wus_drop = 0; got_wr = 0;
    while (cyc < 6000) begin
      if (!o_busy) begin exit_cyc = cyc; break; end
      if (o_sample_ready) bad_rdy = 1;
      if (o_u_wr_en) begin
        got_wr = 1;
        check_eq("wr_addr", o_u_wr_addr, exp_ptr);
        check_eq("wr_data", $signed(o_u_wr_data), x);
        check_eq("wr_cyc", cyc, 3);
      end
      if (o_fir_start) begin
        if (fs_cyc < 0) fs_cyc = cyc;
        check_eq("fir_lat", cyc, 4);
        check_eq("sumu_fir", o_sumu, exp_sumu);
      end
      if (o_w_update_start && wus_cyc < 0) wus_cyc = cyc;
      if (wus_cyc >= 0 && cyc <= wus_cyc + w_lat && !o_w_update_start) wus_drop = 1;
      if (o_out_valid) begin
        n_ov++; ov_cyc = cyc;
        check_eq("y_out", $signed(o_y_out), y);
        check_eq("e_out", $signed(o_e_out), exp_e);
        check_eq("e_n_data", $signed(o_e_n_data), exp_e);
      end
      if (rst_wupd && wus_cyc >= 0 && cyc == wus_cyc + 1) begin
        i_sample_valid = 0; i_fir_done = 0; i_w_finsh = 0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_wus", o_w_update_start, 0);
        check_eq("rst_busy", o_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        check_eq("rst_sumu", o_sumu, 1);
        check_eq("rst_head", o_head, TAPS - 1);
        check_eq("rst_ready", o_sample_ready, 1);
        check_eq("rst_terr", o_timeout_err, 0);
        return;
      end
      // drive inputs for the current cycle
      i_sample_valid = hold;
      i_x_in = 16'($urandom); i_d_in = 16'($urandom); i_adapt_en = 1'($urandom);
      i_fir_done = 0; i_w_finsh = 0; i_fir_y = 16'($urandom);
      if (cyc <= 3) begin
        i_fir_done = ($urandom_range(0, 3) == 0);
        i_w_finsh  = ($urandom_range(0, 3) == 0);
      end
      if (dn_cyc >= 0 && cyc > dn_cyc) i_fir_done = ($urandom_range(0, 2) == 0);
      if (fs_cyc >= 0 && !withhold && dn_cyc < 0 && cyc == fs_cyc + fir_lat) begin
        i_fir_done = 1; i_fir_y = 16'(y); dn_cyc = cyc;
      end
      if (wus_cyc >= 0 && cyc == wus_cyc + w_lat) i_w_finsh = 1;
      @(negedge clk);
      cyc++;
    end
    i_sample_valid = 0; i_fir_done = 0; i_w_finsh = 0;
    check_eq("no_hang", exit_cyc > 0, 1);
    check_eq("got_wr", got_wr, 1);
    check_eq("head", o_head, exp_ptr);
    check_eq("sumu_end", o_sumu, exp_sumu);
    check_eq("ready_busy", bad_rdy, 0);
    if (withhold) begin
      exp_terr = 1;
      check_eq("tmo_cycle", exit_cyc, 4100);
      check_eq("tmo_no_ov", n_ov, 0);
    end else begin
      check_eq("ov_count", n_ov, 1);
      if (!adapt) begin
        check_eq("ov_lat", ov_cyc, dn_cyc + 2);
        check_eq("wus_never", wus_cyc, -1);
      end else begin
        check_eq("wus_rise", wus_cyc, dn_cyc + 2);
        check_eq("wus_held", wus_drop, 0);
        check_eq("ov_after_w", ov_cyc, wus_cyc + w_lat + 1);
        check_eq("wus_fall", o_w_update_start, 0);
      end
    end
    check_eq("terr", o_timeout_err, exp_terr);
  endtask

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    check_eq("rst_ready0", o_sample_ready, 1);
    check_eq("rst_sumu0", o_sumu, 1);
    check_eq("rst_head0", o_head, 511);
    check_eq("rst_busy0", o_busy, 0);
    check_eq("rst_wus0", o_w_update_start, 0);
    check_eq("rst_ov0", o_out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_head", o_head, 511);
    check_eq("rel_sumu", o_sumu, 1);
    check_eq("rel_eout", o_e_out, 0);
    check_eq("rel_terr", o_timeout_err, 0);

    run_sample(100, 0, 0, 1, 3, 5, 0, 0);
    check_eq("t1_sumu", o_sumu, 10000);
    check_eq("t1_head", o_head, 0);

    apply_reset();
    for (int i = 0; i < 513; i++) begin
      run_sample(1000, rnd16(), rnd16(), 0, $urandom_range(0, 2), 0, 0, 0);
      if (i == 511) begin
        check_eq("full_sumu", o_sumu, 512000000);
        check_eq("full_head", o_head, 511);
      end
    end
    check_eq("wrap_head", o_head, 0);
    check_eq("wrap_sumu", o_sumu, 512000000);

    run_sample(rnd16(), 30000, -10000, 0, 1, 0, 0, 0);
    check_eq("sat_pos", $signed(o_e_n_data), 32767);
    run_sample(rnd16(), -30000, 10000, 1, 2, 3, 0, 0);
    check_eq("sat_neg", $signed(o_e_n_data), -32768);

    run_sample(rnd16(), rnd16(), rnd16(), 1, 0, 0, 1, 0);
    run_sample(-32768, rnd16(), rnd16(), 0, 4, 0, 0, 0);

    for (int i = 0; i < 150; i++)
      run_sample(rnd16(), rnd16(), rnd16(), 1'($urandom),
                 $urandom_range(0, 8), $urandom_range(0, 8), 0, 0);

    run_sample(rnd16(), rnd16(), rnd16(), 1, 2, 10, 0, 1);
    run_sample(250, 1000, 400, 1, 1, 2, 0, 0);
    check_eq("post_rst_sumu", o_sumu, 62500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not complete, got 0 expected 1");
    $fatal(1);
  end
endmodule
